// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_BYTE   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    // Keeps only the significant byte-address bits of instruction memory.
    function automatic logic [31:0] addr_mask(input int aw);
        return (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] Address;
    logic [31:0] D_In;
    logic        im_cs;
    logic        im_wr;
    logic        im_rd;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, Address, D_In, im_cs, im_wr, im_rd
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, Address, D_In, im_cs, im_wr, im_rd
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles four accepted bytes into a big-endian word
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[15:0], byte_data_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    // The fourth byte completes the word in the same cycle it is accepted.
    assign word_o       = {shift_q, byte_data_i};
    assign word_ready_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader writing a counted big-endian word stream into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [31:0] ADDR_MASK = addr_mask(ADDR_W);

    if (((BASE_ADDR % 4) != 0) || ((MAX_WORDS * 4 + BASE_ADDR) > (1 << ADDR_W))) begin : g_cfg_check
        $error("imem_loader: BASE_ADDR unaligned or load region exceeds instruction memory");
    end

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        rx_ready_q, wr_q, hold_q, busy_q, done_q, err_q;

    logic        accept;
    logic        pk_clear;
    logic        pk_valid;
    logic        pk_ready;
    logic [31:0] pk_word;

    assign accept   = bus.rx_valid && rx_ready_q;
    assign pk_valid = accept && (state_q == ST_BYTE);

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (reset),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_data_i  (bus.rx_data),
        .word_o       (pk_word),
        .word_ready_o (pk_ready)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        index_d  = index_q;
        addr_d   = addr_q;
        din_d    = din_q;
        pk_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d  = ST_CNT_HI;
                    index_d  = '0;
                    pk_clear = 1'b1;
                end
            end
            ST_CNT_HI: begin
                if (accept) begin
                    count_d[15:8] = bus.rx_data;
                    state_d       = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    count_d = {count_q[15:8], bus.rx_data};
                    if (count_d == 16'd0)
                        state_d = ST_DONE;
                    else if ({16'd0, count_d} > 32'(MAX_WORDS))
                        state_d = ST_ERR;
                    else
                        state_d = ST_BYTE;
                end
            end
            ST_BYTE: begin
                // Address and data are captured here so they hold steady through WRITE and after.
                if (pk_ready) begin
                    din_d   = pk_word;
                    addr_d  = (32'(BASE_ADDR) + {14'd0, index_q, 2'b00}) & ADDR_MASK;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                index_d = index_q + 16'd1;
                state_d = (index_d == count_q) ? ST_DONE : ST_BYTE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            index_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            rx_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rx_ready_q <= state_d inside {ST_CNT_HI, ST_CNT_LO, ST_BYTE};
            wr_q       <= (state_d == ST_WRITE);
            hold_q     <= state_d inside {ST_CNT_HI, ST_CNT_LO, ST_BYTE, ST_WRITE, ST_ERR};
            busy_q     <= state_d inside {ST_CNT_HI, ST_CNT_LO, ST_BYTE, ST_WRITE};
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERR);
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.Address  = addr_q;
    assign bus.D_In     = din_q;
    assign bus.im_cs    = wr_q;
    assign bus.im_wr    = wr_q;
    assign bus.im_rd    = 1'b0;
    assign cpu_hold     = hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, busy, done, err;

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(12), .BASE_ADDR(0), .MAX_WORDS(1024)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    bit          exp_done, exp_err;

    typedef struct {
        string       name;
        logic [79:0] bytes;
        int          n;
        bit          e_done;
        bit          e_err;
        int          e_nwr;
        logic [31:0] e_last_addr;
        logic [31:0] e_last_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.im_wr) begin
            wr_q.push_back({bus.Address, bus.D_In});
            chk("wr_cs", {31'd0, bus.im_cs}, 32'd1);
            chk("wr_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
            chk("wr_hold", {31'd0, cpu_hold}, 32'd1);
        end
    end

    // Reference: count header, then count big-endian words at consecutive word addresses.
    task automatic model(input logic [7:0] b[$]);
        int cnt;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        cnt = {b[0], b[1]};
        if (cnt == 0) exp_done = 1;
        else if (cnt > 1024) exp_err = 1;
        else begin
            exp_done = 1;
            for (int i = 0; i < cnt; i++)
                exp_q.push_back({(32'(4 * i) & 32'hFFF), b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit inject);
        int budget;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            start = inject && (i == 0);
        end
        @(negedge clk);
        start = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        budget = 0;
        while (!bus.rx_ready && budget < 100) begin
            @(negedge clk);
            start = 1'b0;
            budget++;
        end
        if (budget >= 100) begin
            checks++; failures++;
            $display("FAIL rx_ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
    endtask

    task automatic run_session(input logic [7:0] b[$], input int max_gap, input int inject_at);
        int n;
        wr_q.delete();
        model(b);
        pulse_start();
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        chk("start_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < b.size(); k++)
            send_byte(b[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, k == inject_at);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        n = 0;
        while (!(done || err) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL end_timeout actual=busy expected=done_or_err");
        end
        chk("sess_done", {31'd0, done}, {31'd0, exp_done});
        chk("sess_err", {31'd0, err}, {31'd0, exp_err});
        chk("sess_hold", {31'd0, cpu_hold}, {31'd0, exp_err});
        chk("sess_busy", {31'd0, busy}, 32'd0);
        chk("sess_nwr", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk("wr_addr", wr_q[i][63:32], exp_q[i][63:32]);
            chk("wr_data", wr_q[i][31:0], exp_q[i][31:0]);
        end
    endtask

    initial begin
        vec_t        vecs[4];
        logic [7:0]  bq[$];
        int          cnt;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset and idle
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_im_wr", {31'd0, bus.im_wr}, 32'd0);
            chk("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        end
        chk("rst_addr", bus.Address, 32'd0);
        chk("rst_din", bus.D_In, 32'd0);
        chk("rst_cs", {31'd0, bus.im_cs}, 32'd0);
        chk("rst_rd", {31'd0, bus.im_rd}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        vecs[0] = '{"two_words", 80'h0002DEADBEEF12345678, 10, 1, 0, 2, 32'h4, 32'h12345678};
        vecs[1] = '{"zero_count", {16'h0000, 64'd0}, 2, 1, 0, 0, 32'h0, 32'h0};
        vecs[2] = '{"over_max", {16'h0401, 64'd0}, 2, 0, 1, 0, 32'h0, 32'h0};
        vecs[3] = '{"after_err", {48'h000111223344, 32'd0}, 6, 1, 0, 1, 32'h0, 32'h11223344};

        for (int v = 0; v < 4; v++) begin
            bq.delete();
            for (int k = 0; k < vecs[v].n; k++) bq.push_back(vecs[v].bytes[79-8*k -: 8]);
            run_session(bq, 0, -1);
            chk({vecs[v].name, "_done"}, {31'd0, done}, {31'd0, vecs[v].e_done});
            chk({vecs[v].name, "_err"}, {31'd0, err}, {31'd0, vecs[v].e_err});
            chk({vecs[v].name, "_nwr"}, wr_q.size(), vecs[v].e_nwr);
            if (vecs[v].e_nwr > 0 && wr_q.size() > 0) begin
                chk({vecs[v].name, "_last_addr"}, wr_q[wr_q.size()-1][63:32], vecs[v].e_last_addr);
                chk({vecs[v].name, "_last_data"}, wr_q[wr_q.size()-1][31:0], vecs[v].e_last_data);
            end
        end

        // Zero count: DONE the cycle after the second byte
        wr_q.delete();
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h00, 0, 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("zero_done_latency", {31'd0, done}, 32'd1);
        chk("zero_no_wr", wr_q.size(), 32'd0);

        // Three words with gaps and a stray start mid-word
        bq = '{8'h00, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
               8'hC0, 8'hC1, 8'hC2, 8'hC3};
        run_session(bq, 4, 4);
        chk("three_nwr", wr_q.size(), 32'd3);

        // Random sessions
        for (int s = 0; s < 12; s++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) cnt = 0;
            else if (r == 1) cnt = 1025 + $urandom_range(0, 500);
            else cnt = $urandom_range(1, 4);
            bq.delete();
            bq.push_back(cnt[15:8]);
            bq.push_back(cnt[7:0]);
            if (cnt > 0 && cnt <= 1024)
                for (int k = 0; k < 4 * cnt; k++) bq.push_back(8'($urandom));
            run_session(bq, 3, (bq.size() > 2) ? int'($urandom_range(1, bq.size() - 1)) : -1);
        end

        // Asynchronous reset after six bytes of a two-word load
        wr_q.delete();
        pulse_start();
        bq = '{8'h00, 8'h02, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h6A, 8'h6B};
        for (int k = 0; k < 6; k++) send_byte(bq[k], 0, 0);
        #3 reset = 1'b1;
        #1;
        chk("arst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("arst_din", bus.D_In, 32'd0);
        chk("arst_wr", {31'd0, bus.im_wr}, 32'd0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bq = '{8'h00, 8'h01, 8'hC0, 8'hFF, 8'hEE, 8'h01};
        run_session(bq, 0, -1);
        if (wr_q.size() > 0) chk("arst_first_addr", wr_q[0][63:32], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It is the write-side counterpart to the fetch path that only reads it.
- Receives a byte stream over a valid/ready handshake.
- Parses a 16-bit word count, then assembles big-endian 32-bit instruction words.
- Writes each word to sequential instruction-memory addresses using the memory's chip-select and write strobes.
- Holds the CPU (fetch stalled) while loading. Releases it on completion.

Parameters:
ADDR_W, 12, number of significant byte-address bits of instruction memory (4 KB)
BASE_ADDR, 0, byte address of the first loaded word; must be word aligned
MAX_WORDS, 1024, largest word count accepted; larger counts raise err

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a load session; ignored unless in IDLE, DONE or ERR
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader accepts a byte this cycle
Address  output  32  instruction-memory byte address; bits above ADDR_W are always 0
D_In  output  32  instruction word to write
im_cs  output  1  memory chip select; asserted only in WRITE
im_wr  output  1  memory write strobe; asserted only in WRITE
im_rd  output  1  tied 0
cpu_hold  output  1  high from accepted start until DONE; also high in ERR
busy  output  1  high in CNT_HI, CNT_LO, BYTE and WRITE
done  output  1  high in DONE; sticky until the next start
err  output  1  high in ERR; sticky until the next start

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0 (Address = 0, D_In = 0, cpu_hold = 0). Internal word index, byte counter and word count are cleared.
- Handshake: a byte is accepted on a rising edge when rx_valid && rx_ready. rx_ready = 1 in CNT_HI, CNT_LO and BYTE; 0 in all other states. A byte presented while rx_ready = 0 is not consumed; the sender holds it.
- FSM states and transitions:
  - IDLE: start -> CNT_HI. Clear index, set cpu_hold.
  - CNT_HI: accepted byte -> count[15:8]; go to CNT_LO.
  - CNT_LO: accepted byte -> count[7:0]. Then:
    - full 16-bit count = 0 -> DONE;
    - count > MAX_WORDS -> ERR;
    - otherwise -> BYTE.
  - BYTE: shift register collects 4 accepted bytes, first byte into D_In[31:24] (big-endian). The 2-bit byte counter wraps. On the 4th accepted byte -> WRITE.
  - WRITE: exactly one cycle.
    - im_cs = im_wr = 1.
    - Address = BASE_ADDR + 4*index, truncated to ADDR_W bits.
    - D_In holds the assembled word.
    - Index increments on exit. If the new index = count -> DONE, else -> BYTE.
  - DONE: done = 1, cpu_hold = 0. start -> CNT_HI (clears done and index).
  - ERR: err = 1, cpu_hold = 1. No memory writes. start -> CNT_HI (clears err).
- Latency: the write strobe occurs on the cycle after the 4th byte of each word is accepted. Maximum throughput is 4 bytes per 5 cycles.
- Address and D_In stay stable outside WRITE (last values); memory ignores them when im_cs = 0.
- start in CNT_HI, CNT_LO, BYTE or WRITE is ignored; the session continues.
- rx_valid gaps of any length are allowed in any receiving state; there is no timeout.
- Reset mid-session aborts immediately. Words already written stay in memory. The next session restarts at BASE_ADDR.
- No wrap in practice: MAX_WORDS*4 + BASE_ADDR must be <= 2^ADDR_W. This is checked by an elaboration-time assertion.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, CNT_HI, CNT_LO, BYTE, WRITE, DONE, ERR (3-bit);
  - IMEM_ADDR_W = 12, shared with the fetch unit's address truncation.
- Sub-module byte_packer (4-byte shift register plus 2-bit counter, word_ready pulse) is natural and separately testable. Everything else lives in imem_loader.

Test Plan:
1. Reset, then hold idle 5 cycles -> all outputs 0, rx_ready = 0, no im_wr.
2. start; bytes 00 02 DE AD BE EF 12 34 56 78 sent back-to-back -> im_wr at Address 0x000 with D_In 0xDEADBEEF, then at 0x004 with 0x12345678. rx_ready = 0 in each WRITE cycle. Then done = 1, cpu_hold = 0, busy = 0.
3. start; bytes 00 00 -> DONE the cycle after the second byte, zero im_wr pulses, done = 1.
4. start; bytes 04 01 (1025 > MAX_WORDS) -> err = 1, cpu_hold = 1, no im_wr. A following start plus bytes 00 01 11 22 33 44 -> err cleared, one write of 0x11223344 at 0x000.
5. Randomized rx_valid gaps plus a start pulse mid-word during a 3-word load -> start ignored. Exactly 3 writes at 0x000/0x004/0x008 with correct data.
6. Assert reset asynchronously (between clock edges) after 6 bytes of a 2-word load -> outputs 0 immediately. A new session writes its first word at Address 0x000.
